// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - E/M/W control pipeline with load-use stall, branch flush and operand forwarding
module ctrl_pipe #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUCTRL_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  regwrite_D,
  input  logic [1:0]            resultsrc_D,
  input  logic                  memwrite_D,
  input  logic                  jump_D,
  input  logic                  branch_D,
  input  logic [ALUCTRL_W-1:0]  alucontrol_D,
  input  logic                  alusrc_D,
  input  logic [REG_ADDR_W-1:0] rs1_D,
  input  logic [REG_ADDR_W-1:0] rs2_D,
  input  logic [REG_ADDR_W-1:0] rd_D,
  input  logic                  zero_E,
  output logic                  regwrite_E,
  output logic                  memwrite_E,
  output logic                  jump_E,
  output logic                  branch_E,
  output logic                  alusrc_E,
  output logic [1:0]            resultsrc_E,
  output logic [ALUCTRL_W-1:0]  alucontrol_E,
  output logic [REG_ADDR_W-1:0] rs1_E,
  output logic [REG_ADDR_W-1:0] rs2_E,
  output logic [REG_ADDR_W-1:0] rd_E,
  output logic                  pcsrc_E,
  output logic                  regwrite_M,
  output logic                  memwrite_M,
  output logic [1:0]            resultsrc_M,
  output logic [REG_ADDR_W-1:0] rd_M,
  output logic                  regwrite_W,
  output logic [1:0]            resultsrc_W,
  output logic [REG_ADDR_W-1:0] rd_W,
  output logic                  stall_F,
  output logic                  stall_D,
  output logic                  flush_D,
  output logic                  flush_E,
  output logic [1:0]            forward_a_E,
  output logic [1:0]            forward_b_E
);

  logic lwstall;

  // A taken branch/jump outranks a load-use stall: the stalled instruction is discarded anyway.
  always_comb begin
    pcsrc_E = (zero_E & branch_E) | jump_E;
    lwstall = (resultsrc_E == 2'b01) && (rd_E != '0) &&
              ((rd_E == rs1_D) || (rd_E == rs2_D));
    stall_F = lwstall & ~pcsrc_E;
    stall_D = lwstall & ~pcsrc_E;
    flush_D = pcsrc_E;
    flush_E = (lwstall & ~pcsrc_E) | pcsrc_E;
  end

  always_comb begin
    forward_a_E = 2'b00;
    forward_b_E = 2'b00;
    if (regwrite_M && (rd_M != '0) && (rd_M == rs1_E))
      forward_a_E = 2'b10;
    else if (regwrite_W && (rd_W != '0) && (rd_W == rs1_E))
      forward_a_E = 2'b01;
    if (regwrite_M && (rd_M != '0) && (rd_M == rs2_E))
      forward_b_E = 2'b10;
    else if (regwrite_W && (rd_W != '0) && (rd_W == rs2_E))
      forward_b_E = 2'b01;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_E   <= 1'b0;
      memwrite_E   <= 1'b0;
      jump_E       <= 1'b0;
      branch_E     <= 1'b0;
      alusrc_E     <= 1'b0;
      resultsrc_E  <= 2'b00;
      alucontrol_E <= '0;
      rs1_E        <= '0;
      rs2_E        <= '0;
      rd_E         <= '0;
    end else if (flush_E) begin
      regwrite_E   <= 1'b0;
      memwrite_E   <= 1'b0;
      jump_E       <= 1'b0;
      branch_E     <= 1'b0;
      alusrc_E     <= 1'b0;
      resultsrc_E  <= 2'b00;
      alucontrol_E <= '0;
      rs1_E        <= '0;
      rs2_E        <= '0;
      rd_E         <= '0;
    end else begin
      regwrite_E   <= regwrite_D;
      memwrite_E   <= memwrite_D;
      jump_E       <= jump_D;
      branch_E     <= branch_D;
      alusrc_E     <= alusrc_D;
      resultsrc_E  <= resultsrc_D;
      alucontrol_E <= alucontrol_D;
      rs1_E        <= rs1_D;
      rs2_E        <= rs2_D;
      rd_E         <= rd_D;
    end
  end

  // M and W never stall or bubble; they only honour reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_M  <= 1'b0;
      memwrite_M  <= 1'b0;
      resultsrc_M <= 2'b00;
      rd_M        <= '0;
      regwrite_W  <= 1'b0;
      resultsrc_W <= 2'b00;
      rd_W        <= '0;
    end else begin
      regwrite_M  <= regwrite_E;
      memwrite_M  <= memwrite_E;
      resultsrc_M <= resultsrc_E;
      rd_M        <= rd_E;
      regwrite_W  <= regwrite_M;
      resultsrc_W <= resultsrc_M;
      rd_W        <= rd_M;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - self-checking bench for ctrl_pipe against an instruction-level pipeline model
module tb_ctrl_pipe;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic       jump;
    logic       branch;
    logic [2:0] alucontrol;
    logic       alusrc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctl_t;

  logic clk;
  logic reset;
  logic zero_E;
  ctl_t d;

  logic       regwrite_E, memwrite_E, jump_E, branch_E, alusrc_E;
  logic [1:0] resultsrc_E;
  logic [2:0] alucontrol_E;
  logic [4:0] rs1_E, rs2_E, rd_E;
  logic       pcsrc_E;
  logic       regwrite_M, memwrite_M;
  logic [1:0] resultsrc_M;
  logic [4:0] rd_M;
  logic       regwrite_W;
  logic [1:0] resultsrc_W;
  logic [4:0] rd_W;
  logic       stall_F, stall_D, flush_D, flush_E;
  logic [1:0] forward_a_E, forward_b_E;

  ctl_t me, mm, mw;
  int   errors;
  int   checks;

  ctrl_pipe #(.REG_ADDR_W(5), .ALUCTRL_W(3)) dut (
    .clk(clk), .reset(reset),
    .regwrite_D(d.regwrite), .resultsrc_D(d.resultsrc), .memwrite_D(d.memwrite),
    .jump_D(d.jump), .branch_D(d.branch), .alucontrol_D(d.alucontrol), .alusrc_D(d.alusrc),
    .rs1_D(d.rs1), .rs2_D(d.rs2), .rd_D(d.rd), .zero_E(zero_E),
    .regwrite_E(regwrite_E), .memwrite_E(memwrite_E), .jump_E(jump_E), .branch_E(branch_E),
    .alusrc_E(alusrc_E), .resultsrc_E(resultsrc_E), .alucontrol_E(alucontrol_E),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .pcsrc_E(pcsrc_E),
    .regwrite_M(regwrite_M), .memwrite_M(memwrite_M), .resultsrc_M(resultsrc_M), .rd_M(rd_M),
    .regwrite_W(regwrite_W), .resultsrc_W(resultsrc_W), .rd_W(rd_W),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
    .forward_a_E(forward_a_E), .forward_b_E(forward_b_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [50:0] got = {regwrite_E, resultsrc_E, memwrite_E, jump_E, branch_E, alucontrol_E,
                     alusrc_E, rs1_E, rs2_E, rd_E, pcsrc_E,
                     regwrite_M, memwrite_M, resultsrc_M, rd_M,
                     regwrite_W, resultsrc_W, rd_W,
                     stall_F, stall_D, flush_D, flush_E, forward_a_E, forward_b_E};

  function automatic logic m_pcsrc();
    return (zero_E && me.branch) || me.jump;
  endfunction

  function automatic logic m_loaduse();
    return me.resultsrc == 2'b01 && me.rd != 0 && (me.rd == d.rs1 || me.rd == d.rs2);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (mm.regwrite && mm.rd != 0 && mm.rd == rs) return 2'd2;
    if (mw.regwrite && mw.rd != 0 && mw.rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [50:0] m_expect();
    logic st, br;
    br = m_pcsrc();
    st = m_loaduse() && !br;
    return {me, br, mm.regwrite, mm.memwrite, mm.resultsrc, mm.rd,
            mw.regwrite, mw.resultsrc, mw.rd,
            st, st, br, st || br, m_fwd(me.rs1), m_fwd(me.rs2)};
  endfunction

  // One clock: the model retires an instruction per stage, inserting a bubble into E on a kill.
  task automatic tick();
    logic kill;
    @(posedge clk);
    kill = m_pcsrc() || m_loaduse();
    if (reset) begin
      me = '0; mm = '0; mw = '0;
    end else begin
      mw = mm;
      mm = me;
      me = kill ? ctl_t'(0) : d;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    d      = ctl_t'($urandom);
    zero_E = 1'b1;
    tick();
    d = ctl_t'($urandom);
    tick();
    d = '0;
    #1;
    checks++;
    if (got !== 51'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", got, 51'd0);
    end
    checks++;
    if (pcsrc_E !== 1'b0) begin
      errors++; $display("FAIL reset_pcsrc got=%b exp=0", pcsrc_E);
    end
    reset  = 1'b0;
    zero_E = 1'b0;
  endtask

  task automatic test_propagation();
    do_reset();
    d = '0; d.regwrite = 1'b1; d.resultsrc = 2'b10; d.rd = 5'd7;
    tick();
    d = '0;
    checks++;
    if ({regwrite_E, resultsrc_E, rd_E} !== {1'b1, 2'b10, 5'd7}) begin
      errors++; $display("FAIL prop_E got=%b_%b_%0d exp=1_10_7", regwrite_E, resultsrc_E, rd_E);
    end
    tick();
    checks++;
    if ({regwrite_M, resultsrc_M, rd_M} !== {1'b1, 2'b10, 5'd7}) begin
      errors++; $display("FAIL prop_M got=%b_%b_%0d exp=1_10_7", regwrite_M, resultsrc_M, rd_M);
    end
    tick();
    checks++;
    if ({regwrite_W, resultsrc_W, rd_W} !== {1'b1, 2'b10, 5'd7}) begin
      errors++; $display("FAIL prop_W got=%b_%b_%0d exp=1_10_7", regwrite_W, resultsrc_W, rd_W);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    zero_E = 1'b0;
    d = '0; d.regwrite = 1'b1; d.resultsrc = 2'b01; d.rd = 5'd5;
    tick();
    d = '0; d.regwrite = 1'b1; d.rs1 = 5'd9; d.rs2 = 5'd5; d.rd = 5'd12;
    #1;
    checks++;
    if ({stall_F, stall_D, flush_E, flush_D} !== 4'b1110) begin
      errors++; $display("FAIL loaduse_stall got=%b exp=1110", {stall_F, stall_D, flush_E, flush_D});
    end
    tick();
    checks++;
    if ({regwrite_E, rd_E} !== {1'b0, 5'd0}) begin
      errors++; $display("FAIL loaduse_bubble got=%b_%0d exp=0_0", regwrite_E, rd_E);
    end
    d = '0; d.regwrite = 1'b1; d.resultsrc = 2'b01; d.rd = 5'd0;
    tick();
    d = '0; d.rs1 = 5'd0; d.rs2 = 5'd0;
    #1;
    checks++;
    if ({stall_F, stall_D, flush_E, flush_D} !== 4'b0000) begin
      errors++; $display("FAIL loaduse_x0 got=%b exp=0000", {stall_F, stall_D, flush_E, flush_D});
    end
  endtask

  task automatic test_branch();
    do_reset();
    d = '0; d.branch = 1'b1;
    tick();
    d = '0; d.regwrite = 1'b1; d.rd = 5'd9;
    zero_E = 1'b1;
    #1;
    checks++;
    if ({pcsrc_E, flush_D, flush_E, stall_F} !== 4'b1110) begin
      errors++; $display("FAIL branch_taken got=%b exp=1110", {pcsrc_E, flush_D, flush_E, stall_F});
    end
    zero_E = 1'b0;
    #1;
    checks++;
    if ({pcsrc_E, flush_D, flush_E} !== 3'b000) begin
      errors++; $display("FAIL branch_not_taken got=%b exp=000", {pcsrc_E, flush_D, flush_E});
    end
    zero_E = 1'b1;
    tick();
    checks++;
    if ({regwrite_E, rd_E, branch_E} !== {1'b0, 5'd0, 1'b0}) begin
      errors++; $display("FAIL branch_bubble got=%b_%0d_%b exp=0_0_0", regwrite_E, rd_E, branch_E);
    end
    d = '0; d.jump = 1'b1;
    tick();
    d = '0;
    for (int z = 0; z < 2; z++) begin
      zero_E = z[0];
      #1;
      checks++;
      if (pcsrc_E !== 1'b1) begin
        errors++; $display("FAIL jump_pcsrc zero=%0d got=%b exp=1", z, pcsrc_E);
      end
    end
    zero_E = 1'b0;
  endtask

  task automatic test_forwarding();
    do_reset();
    zero_E = 1'b0;
    d = '0; d.regwrite = 1'b1; d.rd = 5'd3; tick();
    d = '0; d.regwrite = 1'b1; d.rd = 5'd3; tick();
    d = '0; d.rs1 = 5'd3; d.rs2 = 5'd0; tick();
    d = '0;
    checks++;
    if ({forward_a_E, forward_b_E} !== 4'b1000) begin
      errors++; $display("FAIL fwd_m_priority got=%b_%b exp=10_00", forward_a_E, forward_b_E);
    end
    d = '0; d.regwrite = 1'b1; d.rd = 5'd3; tick();
    d = '0; d.regwrite = 1'b0; d.rd = 5'd3; tick();
    d = '0; d.rs1 = 5'd3; d.rs2 = 5'd3; tick();
    d = '0;
    checks++;
    if ({forward_a_E, forward_b_E} !== 4'b0101) begin
      errors++; $display("FAIL fwd_w_only got=%b_%b exp=01_01", forward_a_E, forward_b_E);
    end
    d = '0; d.regwrite = 1'b1; d.rd = 5'd0; tick();
    d = '0; tick();
    d = '0; d.rs1 = 5'd0; d.rs2 = 5'd0; tick();
    d = '0;
    checks++;
    if ({forward_a_E, forward_b_E} !== 4'b0000) begin
      errors++; $display("FAIL fwd_x0 got=%b_%b exp=00_00", forward_a_E, forward_b_E);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    zero_E = 1'b0;
    d = '0; d.regwrite = 1'b1; d.resultsrc = 2'b01; d.rd = 5'd6; tick();
    d = '0; d.regwrite = 1'b1; d.rs1 = 5'd6; d.rd = 5'd8; tick();
    d = '0; d.rs1 = 5'd8; d.rs2 = 5'd6; d.regwrite = 1'b1; d.resultsrc = 2'b01; d.rd = 5'd8;
    tick();
    d.rs1 = 5'd8;
    #1;
    checks++;
    if (stall_F !== 1'b1) begin
      errors++; $display("FAIL midreset_pre_stall got=%b exp=1", stall_F);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (got !== 51'd0) begin
      errors++; $display("FAIL midreset_clear got=%h exp=%h", got, 51'd0);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      d        = ctl_t'($urandom);
      d.rs1    = 5'($urandom_range(0, 3));
      d.rs2    = 5'($urandom_range(0, 3));
      d.rd     = 5'($urandom_range(0, 3));
      d.jump   = ($urandom_range(0, 7) == 0);
      d.branch = ($urandom_range(0, 3) == 0);
      zero_E   = 1'($urandom);
      reset    = ($urandom_range(0, 40) == 0);
      #1;
      checks++;
      if (got !== m_expect()) begin
        errors++; $display("FAIL random cycle=%0d got=%h exp=%h", i, got, m_expect());
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    zero_E = 1'b0;
    d      = '0;
    me = '0; mm = '0; mw = '0;
    test_reset();
    test_propagation();
    test_load_use();
    test_branch();
    test_forwarding();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Control-and-hazard pipeline that consumes the decode-stage control word and carries it through the E, M and W stages.
- Generates pcsrc_E from the E-stage branch/jump state and ALU zero.
- Detects load-use hazards and issues stall/flush requests to the fetch and decode datapath registers.
- Produces E-stage operand forwarding selects.
- Sits directly downstream of the decode controller and beside the datapath pipeline registers.

Parameters:
REG_ADDR_W, 5, register-index width (rs1/rs2/rd)
ALUCTRL_W, 3, ALU control word width

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  synchronous, active-high reset
regwrite_D  input  1  D-stage register write enable
resultsrc_D  input  2  D-stage result select (00 ALU, 01 memory, 10 PC+4)
memwrite_D  input  1  D-stage store enable
jump_D  input  1  D-stage jump
branch_D  input  1  D-stage branch
alucontrol_D  input  ALUCTRL_W  D-stage ALU operation
alusrc_D  input  1  D-stage ALU B-source select
rs1_D, rs2_D, rd_D  input  REG_ADDR_W each  D-stage register indices
zero_E  input  1  ALU zero flag, E stage
regwrite_E, memwrite_E, jump_E, branch_E, alusrc_E  output  1 each  E-stage control
resultsrc_E  output  2  E-stage result select
alucontrol_E  output  ALUCTRL_W  E-stage ALU operation
rs1_E, rs2_E, rd_E  output  REG_ADDR_W each  E-stage indices
pcsrc_E  output  1  take branch/jump target
regwrite_M, memwrite_M  output  1 each  M-stage control
resultsrc_M  output  2  M-stage result select
rd_M  output  REG_ADDR_W  M-stage destination
regwrite_W  output  1  W-stage write enable
resultsrc_W  output  2  W-stage result select
rd_W  output  REG_ADDR_W  W-stage destination
stall_F, stall_D  output  1 each  hold PC / IF-ID register
flush_D  output  1  clear IF-ID register
flush_E  output  1  informational copy of internal E bubble
forward_a_E, forward_b_E  output  2 each  E operand select (00 regfile, 01 W result, 10 M ALU result)

Behaviour:
- Reset (synchronous, sampled at clk edge) clears every E/M/W register to 0.
  - Consequently pcsrc_E=0, all forwards=00, stalls=0 and flushes=0 after reset.
  - Reset overrides flush and load in the same cycle.
  - Reset asserted mid-stream discards all in-flight control on that edge.
- Latency: D control appears on E outputs 1 cycle later, M after 2, W after 3 (unless bubbled).
- M and W registers advance every cycle; there is no stall or flush on M or W.
- E register priority: reset > flush_E (load all-zero bubble: NOP, regwrite=0, memwrite=0, branch=0, jump=0, rd=0) > load D values.
- pcsrc_E = (zero_E & branch_E) | jump_E; this is combinational from E registers and zero_E.
- lwstall = (resultsrc_E==01) & (rd_E!=0) & ((rd_E==rs1_D) | (rd_E==rs2_D)).
- stall_F = stall_D = lwstall & ~pcsrc_E.
- flush_D = pcsrc_E.
- flush_E = (lwstall & ~pcsrc_E) | pcsrc_E.
- The lwstall/pcsrc overlap cannot occur in legal code (a load in E has branch_E=jump_E=0); the gating above still defines it: a taken branch wins.
- Forwarding for A (B identical with rs2_E):
  - 10 if regwrite_M & rd_M!=0 & rd_M==rs1_E;
  - else 01 if regwrite_W & rd_W!=0 & rd_W==rs1_E;
  - else 00.
  - M has priority over W.
- Register x0 never triggers forwarding or stall.
- All stall/flush/forward outputs are combinational from current registers and D inputs; no combinational path exists from zero_E to stall outputs except through the pcsrc gating.

Test Plan:
- Reset: hold reset 2 cycles with random D inputs -> all E/M/W outputs 0, pcsrc_E=0, forwards 00, stall/flush 0.
- Propagation: regwrite_D=1, resultsrc_D=10, rd_D=7 for one cycle, then zeros -> regwrite_E/rd_E=1/7 at +1, regwrite_M/rd_M at +2, regwrite_W/rd_W=1/7 with resultsrc_W=10 at +3.
- Load-use: E holds resultsrc_E=01, rd_E=5, D has rs2_D=5 -> stall_F=stall_D=flush_E=1, flush_D=0; next cycle E is bubble (regwrite_E=0, rd_E=0); repeat with rd_E=0 -> no stall.
- Branch: branch_E=1 with zero_E=1 -> pcsrc_E=flush_D=flush_E=1 and E bubble next cycle; zero_E=0 -> all 0; jump_E=1 -> pcsrc_E=1 regardless of zero_E.
- Forwarding priority: rd_M=rd_W=3, both regwrite=1, rs1_E=3 -> forward_a_E=10; regwrite_M=0 -> 01; rs2_E=0 with rd_W=0 -> forward_b_E=00.
- Reset mid-stream: assert reset while a load-use stall is active -> next cycle all registers 0, stall_F=0.
